// File: rtl/vjtag_pkg.sv
// Shared constants for the virtual-JTAG register bank: instruction codes,
// STATUS word layout and the default block version.
package vjtag_pkg;

    localparam logic [7:0] VERSION_DEFAULT = 8'h01;

    localparam int IR_BYPASS = 0;

    localparam int ST_VER_LSB  = 0;
    localparam int ST_NREG_LSB = 8;
    localparam int ST_ERR_LSB  = 16;
    localparam int ST_W        = 24;

    // STATUS is the all-ones instruction for whatever IR width is in use
    function automatic int ir_status(input int ir_w);
        return (1 << ir_w) - 1;
    endfunction

endpackage

// File: rtl/vjtag_shift_core.sv
// DR shift engine: capture/shift register, saturating bit counter, bypass
// flop and the combinational tdo select.
module vjtag_shift_core #(
    parameter int SR_W  = 32,
    parameter int CNT_W = 6
) (
    input  logic             tck,
    input  logic             rst_n,
    input  logic             tdi,
    input  logic             cdr,
    input  logic             sdr,
    input  logic             sel_bypass,
    input  logic [SR_W-1:0]  cap_val,
    output logic [SR_W-1:0]  sr,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             tdo
);

    logic bypass;

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            bypass  <= 1'b0;
        end else if (cdr) begin
            sr      <= cap_val;
            bit_cnt <= '0;
            bypass  <= 1'b0;
        end else if (sdr) begin
            sr     <= {tdi, sr[SR_W-1:1]};
            bypass <= tdi;
            // saturating one past full length keeps long scans distinguishable
            if (bit_cnt != CNT_W'(SR_W + 1))
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign tdo = sel_bypass ? bypass : sr[0];

endmodule

// File: rtl/vjtag_reg_bank.sv
// Virtual-JTAG data-register bank: IR decode, user registers, update strobes
// and length-error tracking. VJTAG_PARITY_EN adds an even-parity bit per scan.
module vjtag_reg_bank
    import vjtag_pkg::*;
#(
    parameter int              IR_W     = 3,
    parameter int              DR_W     = 32,
    parameter int              NUM_REGS = 4,
    parameter logic [DR_W-1:0] RST_VAL  = '0,
    parameter logic [7:0]      VERSION  = VERSION_DEFAULT
) (
    input  logic                     tck,
    input  logic                     rst_n,
    input  logic                     tdi,
    output logic                     tdo,
    input  logic [IR_W-1:0]          ir_in,
    output logic [IR_W-1:0]          ir_out,
    input  logic                     virtual_state_cdr,
    input  logic                     virtual_state_sdr,
    input  logic                     virtual_state_udr,
    input  logic                     virtual_state_cir,
    input  logic                     virtual_state_uir,
    output logic [NUM_REGS*DR_W-1:0] reg_q,
    input  logic [NUM_REGS*DR_W-1:0] reg_d,
    output logic [NUM_REGS-1:0]      upd_stb,
`ifdef VJTAG_PARITY_EN
    output logic                     par_err,
`endif
    output logic                     len_err
);

`ifdef VJTAG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SR_W  = DR_W + PAR;
    localparam int CNT_W = $clog2(SR_W + 2);

    logic [IR_W-1:0]  ch_q;
    logic [7:0]       err_cnt;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  cap_val;
    logic [CNT_W-1:0] bit_cnt;
    logic [DR_W-1:0]  cap_word;
    logic [ST_W-1:0]  st_word;
    logic             udr_eff;
    logic             user_udr;
    logic             len_ok;
    logic             par_ok;
    logic             err_hit;

    function automatic logic is_user(input logic [IR_W-1:0] code);
        return (code != '0) && (int'(code) <= NUM_REGS);
    endfunction

    function automatic logic is_status(input logic [IR_W-1:0] code);
        return code == IR_W'(ir_status(IR_W));
    endfunction

    always_comb begin
        st_word                     = '0;
        st_word[ST_VER_LSB  +: 8]   = VERSION;
        st_word[ST_NREG_LSB +: 8]   = 8'(NUM_REGS);
        st_word[ST_ERR_LSB  +: 8]   = err_cnt;
        cap_word = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (ir_in == IR_W'(k + 1))
                cap_word = reg_d[k*DR_W +: DR_W];
        if (is_status(ir_in))
            cap_word = DR_W'(st_word);
`ifdef VJTAG_PARITY_EN
        cap_val = {^cap_word, cap_word};
`else
        cap_val = cap_word;
`endif
    end

    vjtag_shift_core #(
        .SR_W  (SR_W),
        .CNT_W (CNT_W)
    ) u_shift (
        .tck        (tck),
        .rst_n      (rst_n),
        .tdi        (tdi),
        .cdr        (virtual_state_cdr),
        .sdr        (virtual_state_sdr),
        .sel_bypass (!(is_user(ch_q) || is_status(ch_q))),
        .cap_val    (cap_val),
        .sr         (sr),
        .bit_cnt    (bit_cnt),
        .tdo        (tdo)
    );

    // CDR and SDR outrank UDR when the hub asserts several at once
    assign udr_eff  = virtual_state_udr && !virtual_state_cdr && !virtual_state_sdr;
    assign user_udr = udr_eff && is_user(ch_q);
    assign len_ok   = (bit_cnt == CNT_W'(SR_W));
`ifdef VJTAG_PARITY_EN
    assign par_ok   = (sr[SR_W-1] == ^sr[DR_W-1:0]);
`else
    assign par_ok   = 1'b1;
`endif
    assign err_hit  = user_udr && !(len_ok && par_ok);

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            ch_q    <= '0;
            reg_q   <= {NUM_REGS{RST_VAL}};
            upd_stb <= '0;
            len_err <= 1'b0;
            err_cnt <= '0;
            ir_out  <= '0;
`ifdef VJTAG_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            upd_stb <= '0;
            if (virtual_state_cdr)
                ch_q <= ir_in;
            if (virtual_state_cir)
                ir_out <= {len_err, {(IR_W-1){1'b0}}};
            // reading STATUS through an IR update acknowledges the sticky flags
            if (virtual_state_uir && is_status(ir_in)) begin
                len_err <= 1'b0;
`ifdef VJTAG_PARITY_EN
                par_err <= 1'b0;
`endif
            end
            if (err_hit && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (user_udr) begin
                if (!len_ok) begin
                    len_err <= 1'b1;
                end else if (!par_ok) begin
`ifdef VJTAG_PARITY_EN
                    par_err <= 1'b1;
`endif
                end else begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (ch_q == IR_W'(k + 1)) begin
                            reg_q[k*DR_W +: DR_W] <= sr[DR_W-1:0];
                            upd_stb[k]            <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
